// File: rtl/onehot_sequencer.sv
// onehot_sequencer: parametrised one-hot channel sequencer for register clock
// enables or display-digit selects. It supports per-channel dwell, ascending or
// descending rotation, pause, direct load, and a single-sweep mode with a
// busy/done handshake. All outputs are registered.
//
// Optional build macro SEQ_BLANK_EN: break-before-make blanking. When it is
// defined and DWELL >= 2, saida is forced to zero for the first cycle after
// every advance or load. When it is undefined, no blanking logic is built.
module onehot_sequencer #(
  parameter int N     = 4,  // channel count, >= 2
  parameter int IDX_W = 2,  // ceil(log2(N))
  parameter int DWELL = 1,  // cycles per channel, >= 1
  parameter int CNT_W = 4   // dwell counter width, 2**CNT_W >= DWELL
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             dir,
  input  logic             mode,
  input  logic             start,
  input  logic             load,
  input  logic [IDX_W-1:0] load_idx,
  output logic [N-1:0]     saida,
  output logic [IDX_W-1:0] idx,
  output logic             wrap,
  output logic             busy,
  output logic             done
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(N - 1);
  localparam logic [IDX_W:0]   N_EXT      = (IDX_W + 1)'(N);
  localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL - 1);
  localparam logic [N-1:0]     ONE        = N'(1);

  state_t           state, state_nx;
  logic [IDX_W-1:0] idx_nx;
  logic [CNT_W-1:0] dwell_cnt, dwell_nx;
  logic [IDX_W-1:0] sweep_cnt, sweep_nx;
  logic [N-1:0]     saida_nx;
  logic             wrap_nx, done_nx, advance;
  logic             step_ok, load_ok;

  // A load is honoured only when it targets an existing channel. This keeps a
  // non-power-of-two N from ever reaching an idx value >= N.
  assign load_ok = load && ({1'b0, load_idx} < N_EXT);

  // Stepping runs freely in continuous mode, and only during RUN in sweep mode.
  assign step_ok = en && (!mode || state == RUN);

  // Next-state logic: load beats advance, and the FSM tracks sweep progress.
  always_comb begin
    // NOTE: every signal driven here gets a default first, so no latch is inferred.
    state_nx = state;
    idx_nx   = idx;
    dwell_nx = dwell_cnt;
    sweep_nx = sweep_cnt;
    wrap_nx  = 1'b0;
    done_nx  = 1'b0;
    advance  = 1'b0;

    if (load_ok) begin
      idx_nx   = load_idx;
      dwell_nx = '0;
    end else if (step_ok) begin
      if (dwell_cnt == DWELL_LAST) begin
        advance  = 1'b1;
        dwell_nx = '0;
        if (!dir) begin
          if (idx == IDX_LAST) begin
            idx_nx  = '0;
            wrap_nx = 1'b1;
          end else begin
            idx_nx = idx + IDX_W'(1);
          end
        end else begin
          if (idx == '0) begin
            idx_nx  = IDX_LAST;
            wrap_nx = 1'b1;
          end else begin
            idx_nx = idx - IDX_W'(1);
          end
        end
      end else begin
        dwell_nx = dwell_cnt + CNT_W'(1);
      end
    end

    unique case (state)
      IDLE: begin
        if (mode && start) begin
          state_nx = RUN;
          sweep_nx = '0;
          dwell_nx = '0;
        end
      end
      RUN: begin
        if (!mode) begin
          // Leaving sweep mode aborts the sweep silently.
          state_nx = IDLE;
        end else if (advance) begin
          if (sweep_cnt == IDX_LAST) begin
            // The N-th advance brings idx back to its start value.
            state_nx = IDLE;
            sweep_nx = '0;
            done_nx  = 1'b1;
          end else begin
            sweep_nx = sweep_cnt + IDX_W'(1);
          end
        end
      end
      default: state_nx = IDLE;
    endcase

`ifdef SEQ_BLANK_EN
    saida_nx = ((DWELL >= 2) && (advance || load_ok)) ? '0 : (ONE << idx_nx);
`else
    saida_nx = ONE << idx_nx;
`endif
  end

  // State and output registers; reset puts channel 0 on the output immediately.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values of the others.
    if (rst) begin
      state     <= IDLE;
      idx       <= '0;
      saida     <= ONE;
      dwell_cnt <= '0;
      sweep_cnt <= '0;
      wrap      <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_nx;
      idx       <= idx_nx;
      saida     <= saida_nx;
      dwell_cnt <= dwell_nx;
      sweep_cnt <= sweep_nx;
      wrap      <= wrap_nx;
      busy      <= (state_nx == RUN);
      done      <= done_nx;
    end
  end

endmodule

// File: tb/tb_onehot_sequencer.sv
// tb_onehot_sequencer: table-driven and hand-sequenced checks of three
// onehot_sequencer configurations that share one stimulus bus:
//   dut 0: N=4, DWELL=1   dut 1: N=5, DWELL=3   dut 2: N=4, DWELL=2
// Expected results are queued as stimulus is driven, then popped and compared
// after the next rising edge. Expectations follow SEQ_BLANK_EN when it is defined.
module tb_onehot_sequencer;

`ifdef SEQ_BLANK_EN
  localparam bit BLANK = 1'b1;
`else
  localparam bit BLANK = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       en = 1'b0, dir = 1'b0, mode = 1'b0, start = 1'b0, load = 1'b0;
  logic [2:0] load_idx = '0;

  logic [3:0] saida_a, saida_c;
  logic [4:0] saida_b;
  logic [1:0] idx_a, idx_c;
  logic [2:0] idx_b;
  logic       wrap_a, busy_a, done_a;
  logic       wrap_b, busy_b, done_b;
  logic       wrap_c, busy_c, done_c;

  onehot_sequencer #(.N(4), .IDX_W(2), .DWELL(1), .CNT_W(4)) u_a (
    .clk(clk), .rst(rst), .en(en), .dir(dir), .mode(mode), .start(start),
    .load(load), .load_idx(load_idx[1:0]), .saida(saida_a), .idx(idx_a),
    .wrap(wrap_a), .busy(busy_a), .done(done_a));

  onehot_sequencer #(.N(5), .IDX_W(3), .DWELL(3), .CNT_W(2)) u_b (
    .clk(clk), .rst(rst), .en(en), .dir(dir), .mode(mode), .start(start),
    .load(load), .load_idx(load_idx), .saida(saida_b), .idx(idx_b),
    .wrap(wrap_b), .busy(busy_b), .done(done_b));

  onehot_sequencer #(.N(4), .IDX_W(2), .DWELL(2), .CNT_W(2)) u_c (
    .clk(clk), .rst(rst), .en(en), .dir(dir), .mode(mode), .start(start),
    .load(load), .load_idx(load_idx[1:0]), .saida(saida_c), .idx(idx_c),
    .wrap(wrap_c), .busy(busy_c), .done(done_c));

  always #5 clk = ~clk;

  // One stimulus row and the expected state after the following edge.
  typedef struct {
    logic       en, dir, mode, start, load;
    logic [2:0] lidx;
    int         idx;
    logic       fresh, wrap, busy, done;
  } vec_t;

  typedef struct {
    int    dut;
    string name;
    int    idx;
    logic  fresh, wrap, busy, done;
  } exp_t;

  exp_t sb[$];
  vec_t vecs[$];
  int   compared = 0;
  int   failed   = 0;

  function automatic vec_t v(logic en_i, logic dir_i, logic mode_i, logic start_i,
                             logic load_i, logic [2:0] lidx_i, int idx_i,
                             logic fresh_i, logic wrap_i, logic busy_i, logic done_i);
    vec_t r;
    r.en = en_i; r.dir = dir_i; r.mode = mode_i; r.start = start_i; r.load = load_i;
    r.lidx = lidx_i; r.idx = idx_i; r.fresh = fresh_i; r.wrap = wrap_i;
    r.busy = busy_i; r.done = done_i;
    return r;
  endfunction

  // Pop the oldest expectation and compare it with the selected DUT's outputs.
  task automatic check();
    exp_t       e;
    logic [7:0] gs, ws;
    logic [2:0] gi;
    logic       gw, gb, gd;
    e = sb.pop_front();
    case (e.dut)
      0:       begin gs = 8'(saida_a); gi = 3'(idx_a); gw = wrap_a; gb = busy_a; gd = done_a; end
      1:       begin gs = 8'(saida_b); gi = idx_b;     gw = wrap_b; gb = busy_b; gd = done_b; end
      default: begin gs = 8'(saida_c); gi = 3'(idx_c); gw = wrap_c; gb = busy_c; gd = done_c; end
    endcase
    ws = (BLANK && e.fresh) ? 8'h00 : (8'h01 << e.idx);
    compared++;
    if (gs !== ws || gi !== 3'(e.idx) || gw !== e.wrap || gb !== e.busy || gd !== e.done) begin
      failed++;
      $display("FAIL %s (dut %0d): got saida=%b idx=%0d wrap=%b busy=%b done=%b, expected saida=%b idx=%0d wrap=%b busy=%b done=%b",
               e.name, e.dut, gs, gi, gw, gb, gd, ws, e.idx, e.wrap, e.busy, e.done);
    end
  endtask

  // Drive one row, queue its expectation, and compare just after the next edge.
  task automatic step(input int dut, input string name, input vec_t t);
    exp_t e;
    en = t.en; dir = t.dir; mode = t.mode; start = t.start; load = t.load; load_idx = t.lidx;
    e.dut = dut; e.name = name; e.idx = t.idx; e.fresh = t.fresh;
    e.wrap = t.wrap; e.busy = t.busy; e.done = t.done;
    sb.push_back(e);
    @(posedge clk);
    #1;
    check();
  endtask

  // Assert reset between edges and check every DUT before any edge can occur.
  task automatic do_reset(input string name);
    exp_t e;
    en = 1'b0; dir = 1'b0; mode = 1'b0; start = 1'b0; load = 1'b0; load_idx = '0;
    rst = 1'b1;
    #2;
    for (int d = 0; d < 3; d++) begin
      e.dut = d; e.name = name; e.idx = 0; e.fresh = 1'b0;
      e.wrap = 1'b0; e.busy = 1'b0; e.done = 1'b0;
      sb.push_back(e);
      check();
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #1;
    do_reset("reset_initial");

    // dut 0 (N=4, DWELL=1). Columns: en dir mode start load lidx | idx fresh wrap busy done
    vecs.push_back(v(1,0,0,0,0,0, 1,0,0,0,0));
    vecs.push_back(v(1,0,0,0,0,0, 2,0,0,0,0));
    vecs.push_back(v(1,0,0,0,0,0, 3,0,0,0,0));
    vecs.push_back(v(1,0,0,0,0,0, 0,0,1,0,0)); // ascending wrap 3 -> 0
    vecs.push_back(v(0,0,0,0,0,0, 0,0,0,0,0)); // en=0 freezes
    vecs.push_back(v(1,1,0,0,0,0, 3,0,1,0,0)); // descending wrap 0 -> 3
    vecs.push_back(v(1,1,0,0,0,0, 2,0,0,0,0));
    vecs.push_back(v(0,1,0,0,0,0, 2,0,0,0,0)); // hold for 3 cycles
    vecs.push_back(v(0,1,0,0,0,0, 2,0,0,0,0));
    vecs.push_back(v(0,1,0,0,0,0, 2,0,0,0,0));
    vecs.push_back(v(0,0,0,0,1,1, 1,0,0,0,0)); // load honoured with en=0
    vecs.push_back(v(1,0,0,0,1,3, 3,0,0,0,0)); // load beats advance
    vecs.push_back(v(1,0,0,0,0,0, 0,0,1,0,0));
    vecs.push_back(v(1,0,1,0,0,0, 0,0,0,0,0)); // sweep mode, IDLE holds
    vecs.push_back(v(1,0,1,1,0,0, 0,0,0,1,0)); // start: RUN, no advance yet
    vecs.push_back(v(1,0,1,1,0,0, 1,0,0,1,0)); // start in RUN ignored
    vecs.push_back(v(1,0,1,0,0,0, 2,0,0,1,0));
    vecs.push_back(v(1,0,1,0,0,0, 3,0,0,1,0));
    vecs.push_back(v(1,0,1,0,0,0, 0,0,1,0,1)); // 4th advance: done
    vecs.push_back(v(1,0,1,0,0,0, 0,0,0,0,0)); // back in IDLE
    vecs.push_back(v(1,0,1,1,0,0, 0,0,0,1,0));
    vecs.push_back(v(1,0,1,0,0,0, 1,0,0,1,0));
    vecs.push_back(v(1,0,0,0,0,0, 2,0,0,0,0)); // mode=0 aborts, no done
    vecs.push_back(v(1,0,0,0,0,0, 3,0,0,0,0));
    vecs.push_back(v(1,0,1,0,0,0, 3,0,0,0,0)); // confirms IDLE
    foreach (vecs[i]) step(0, $sformatf("tab_a_%0d", i), vecs[i]);

    // dut 1 (N=5, DWELL=3): load, out-of-range loads, wrap in both directions.
    do_reset("reset_b");
    step(1, "b_load4",      v(1,0,0,0,1,4, 4,1,0,0,0));
    step(1, "b_dwell1",     v(1,0,0,0,0,0, 4,0,0,0,0));
    step(1, "b_dwell2",     v(1,0,0,0,0,0, 4,0,0,0,0));
    step(1, "b_wrap_up",    v(1,0,0,0,0,0, 0,1,1,0,0));
    step(1, "b_load6_ign",  v(1,0,0,0,1,6, 0,0,0,0,0));
    step(1, "b_load5_ign",  v(1,0,0,0,1,5, 0,0,0,0,0));
    step(1, "b_load7_step", v(1,0,0,0,1,7, 1,1,0,0,0));
    step(1, "b_load0",      v(1,1,0,0,1,0, 0,1,0,0,0));
    step(1, "b_dn_dwell1",  v(1,1,0,0,0,0, 0,0,0,0,0));
    step(1, "b_dn_dwell2",  v(1,1,0,0,0,0, 0,0,0,0,0));
    step(1, "b_wrap_dn",    v(1,1,0,0,0,0, 4,1,1,0,0));
    step(1, "b_dn_hold1",   v(1,1,0,0,0,0, 4,0,0,0,0));
    step(1, "b_dn_hold2",   v(1,1,0,0,0,0, 4,0,0,0,0));
    step(1, "b_dn_step",    v(1,1,0,0,0,0, 3,1,0,0,0));

    // dut 2 (N=4, DWELL=2): sweep from idx 1 with an ignored start and a pause.
    do_reset("reset_c");
    step(2, "c_load1",      v(0,0,1,0,1,1, 1,1,0,0,0));
    step(2, "c_start",      v(1,0,1,1,0,0, 1,0,0,1,0));
    step(2, "c_e1",         v(1,0,1,0,0,0, 1,0,0,1,0));
    step(2, "c_e2",         v(1,0,1,0,0,0, 2,1,0,1,0));
    step(2, "c_e3_start",   v(1,0,1,1,0,0, 2,0,0,1,0));
    step(2, "c_pause1",     v(0,0,1,0,0,0, 2,0,0,1,0));
    step(2, "c_pause2",     v(0,0,1,0,0,0, 2,0,0,1,0));
    step(2, "c_e4",         v(1,0,1,0,0,0, 3,1,0,1,0));
    step(2, "c_e5",         v(1,0,1,0,0,0, 3,0,0,1,0));
    step(2, "c_e6",         v(1,0,1,0,0,0, 0,1,1,1,0));
    step(2, "c_e7",         v(1,0,1,0,0,0, 0,0,0,1,0));
    step(2, "c_e8_done",    v(1,0,1,0,0,0, 1,1,0,0,1));
    step(2, "c_idle1",      v(1,0,1,0,0,0, 1,0,0,0,0));
    step(2, "c_idle2",      v(1,0,1,0,0,0, 1,0,0,0,0));

    // Load coinciding with the final advance: load wins and the sweep continues.
    step(2, "c2_start",     v(1,0,1,1,0,0, 1,0,0,1,0));
    step(2, "c2_e1",        v(1,0,1,0,0,0, 1,0,0,1,0));
    step(2, "c2_e2",        v(1,0,1,0,0,0, 2,1,0,1,0));
    step(2, "c2_e3",        v(1,0,1,0,0,0, 2,0,0,1,0));
    step(2, "c2_e4",        v(1,0,1,0,0,0, 3,1,0,1,0));
    step(2, "c2_e5",        v(1,0,1,0,0,0, 3,0,0,1,0));
    step(2, "c2_e6",        v(1,0,1,0,0,0, 0,1,1,1,0));
    step(2, "c2_e7",        v(1,0,1,0,0,0, 0,0,0,1,0));
    step(2, "c2_e8_load",   v(1,0,1,0,1,2, 2,1,0,1,0));
    step(2, "c2_e9",        v(1,0,1,0,0,0, 2,0,0,1,0));
    step(2, "c2_e10_done",  v(1,0,1,0,0,0, 3,1,0,0,1));

    // Asynchronous reset in the middle of a sweep: no done pulse follows.
    step(2, "c3_start",     v(1,0,1,1,0,0, 3,0,0,1,0));
    step(2, "c3_e1",        v(1,0,1,0,0,0, 3,0,0,1,0));
    do_reset("reset_midsweep");
    step(2, "c3_post1",     v(1,0,1,0,0,0, 0,0,0,0,0));
    step(2, "c3_post2",     v(1,0,1,0,0,0, 0,0,0,0,0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
    $finish;
  end

  // Guard against a stalled run.
  initial begin
    #200000;
    $display("FAIL watchdog: got no completion by 200000 time units, expected a finished run");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/onehot_sequencer.md
Name: onehot_sequencer

Overview:
Parametrised one-hot channel sequencer that drives per-channel register clock enables or display-digit selects. It is the generalised successor of the fixed 4-way rotating selector. It adds:
- configurable channel count
- per-channel dwell time
- direction control
- pause, direct load and a single-sweep mode with busy/done handshake
It sits between the system clock and the channel register bank or display multiplexer.

Parameters:
N, 4, number of channels; N >= 2, need not be a power of two
IDX_W, 2, index width; must equal ceil(log2(N))
DWELL, 1, cycles each channel stays selected; DWELL >= 1
CNT_W, 4, dwell counter width; 2**CNT_W >= DWELL

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous reset, active-high
en  in  1  advance enable; 0 freezes index, dwell counter and sweep progress
dir  in  1  0 = ascending (idx+1), 1 = descending (idx-1)
mode  in  1  0 = continuous rotation, 1 = single sweep
start  in  1  single-sweep trigger, sampled only in IDLE with mode=1
load  in  1  synchronous jump request
load_idx  in  IDX_W  target channel for load
saida  out  N  one-hot channel select
idx  out  IDX_W  binary index of selected channel
wrap  out  1  one-cycle pulse on wrap-around advance
busy  out  1  high while a single sweep is in progress
done  out  1  one-cycle pulse when a single sweep completes

Behaviour:
- Reset (async, immediate, any state): idx=0, saida=1 (bit 0), dwell counter=0, sweep counter=0, state=IDLE, wrap=0, busy=0, done=0.
- All outputs are registered.
- saida always equals 1<<idx, except during blanking (see Optional Feature).
- Advance tick:
  - Dwell counter increments on each clk where stepping is permitted.
  - When it reaches DWELL-1, the next edge advances idx and clears the counter.
  - DWELL=1 gives one channel per cycle.
- Stepping permitted when en=1 and either mode=0, or mode=1 and state=RUN.
- Index arithmetic:
  - Ascending: N-1 -> 0.
  - Descending: 0 -> N-1.
  - wrap=1 on exactly the edge where one of these transitions occurs, else 0.
  - Non-power-of-two N never produces idx >= N.
- Priority per edge: rst > load > advance.
- Load:
  - When load=1 and load_idx < N: idx<=load_idx, dwell counter<=0, wrap=0, no advance that cycle.
  - When load_idx >= N: load is ignored entirely and normal stepping proceeds.
  - Load is honoured regardless of en and state and does not change state or sweep counter.
- FSM (meaningful in mode=1):
  - IDLE: busy=0, idx held. start=1 -> RUN, sweep counter<=0, dwell counter<=0.
  - RUN: busy=1. Each advance increments sweep counter. The N-th advance returns idx to its start value; on that edge state<=IDLE, done=1 for one cycle, busy=0 from the next cycle.
  - Total sweep length with en held high is N*DWELL cycles.
- start in RUN or while mode=0 is ignored.
- mode switched to 0 during RUN: sweep aborts, state<=IDLE, no done pulse; continuous stepping follows.
- en=0 during RUN pauses the sweep; busy stays 1.
- dir may change at any time; it takes effect on the next advance. The sweep still ends after N advances.
- Simultaneous load and the N-th advance: load wins, sweep counter unchanged, sweep continues.

Optional Feature:
- Macro SEQ_BLANK_EN (break-before-make blanking for display multiplexing).
- Defined:
  - For DWELL >= 2, saida=0 for the first cycle of every dwell period following an advance or load; idx already holds the new value.
  - Not applied after reset.
  - For DWELL=1 there is no effect.
- Undefined: saida is always 1<<idx; no blanking logic is synthesised.

Test Plan:
- N=4, DWELL=1, reset then en=1, mode=0, dir=0 for 4 edges -> saida 0010, 0100, 1000, 0001; wrap=1 only on 4th edge; busy=0.
- N=4, dir=1 from reset, en=1 -> saida 1000 with wrap=1 on first edge, then 0100; en=0 for 3 cycles -> saida holds 0100.
- N=5, DWELL=3, load=1 with load_idx=4 -> idx=4, saida=10000 for 3 cycles, then 00001 with wrap=1; load_idx=6 -> ignored, stepping continues.
- N=4, DWELL=2, mode=1, start pulse at idx=1 -> busy=1 for 8 cycles, done pulses once, idx back to 1, further edges hold idx=1.
- Mid-sweep: assert rst asynchronously between edges -> saida=0001, idx=0, busy=0 immediately, no done pulse; a second start in RUN has no effect.
- SEQ_BLANK_EN, N=4, DWELL=3, en=1 -> saida 0001,0001,0001,0000,0010,0010,0000,0100...
